dcache_controller: RTL and testbench



---
 rtl/dcache_controller_pkg.sv | 38 +++
 rtl/dcache_controller_if.sv | 36 +++
 rtl/dcache_controller_word_mux.sv | 27 ++
 rtl/dcache_controller.sv | 143 ++++++++++++++
 tb/tb_dcache_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the data-cache controller slice.
// Holds address field geometry, the SRAM tag-word layout
// ({valid, dirty, tag}), the controller state encoding and
// a helper that builds line-aligned memory addresses.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned TAG_W      = 23;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WSEL_W     = 3;
  localparam int unsigned SRAM_TAG_W = TAG_W + 2;

  // Address slice positions: tag=[31:9], index=[8:5], word=[4:2]
  localparam int unsigned WORD_LSB   = 2;
  localparam int unsigned INDEX_LSB  = 5;
  localparam int unsigned TAG_LSB    = 9;

  // Bit positions inside the 25-bit SRAM tag word
  localparam int unsigned VALID_BIT  = 24;
  localparam int unsigned DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data-cache controller.
//   cpu_*  : single-word load/store requests and load data / stall
//   mem_*  : line-sized write-back / refill requests and ack
// Modport slave is the controller view, master the environment view.
interface dcache_controller_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;

  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    input  mem_data_i, mem_ack_i,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    output mem_data_i, mem_ack_i,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_controller_word_mux.sv
// Word lane selection within a 256-bit cache line.
//   word_sel_i : word index within the line (addr[4:2])
//   line_i     : line read from the cache SRAM
//   wdata_i    : store data to merge
//   rdata_o    : selected 32-bit word for loads
//   line_o     : line_i with the selected word replaced by wdata_i
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [LINE_W-1:0] line_o
);

  logic [7:0] bit_base;

  assign bit_base = {word_sel_i, 5'b00000};

  always_comb begin
    rdata_o                        = line_i[bit_base +: WORD_W];
    line_o                         = line_i;
    line_o[bit_base +: WORD_W]     = wdata_i;
  end

endmodule

// File: rtl/dcache_controller.sv
// Data-cache controller in front of a 2-way, 16-set, 256-bit-line SRAM.
// Serves single-word CPU loads/stores; on a miss writes back a dirty
// victim, refills the line from memory, then replays the access as a hit.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   bus (slave)       : CPU request/response and memory request/ack
//   cache_sram_*      : index/tag/data/enable/write toward the SRAM
//   sram_cache_*      : tag/data of hit way (or LRU victim), hit flag
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_controller_if.slave    bus,
  output logic [INDEX_W-1:0]    cache_sram_index,
  output logic [SRAM_TAG_W-1:0] cache_sram_tag,
  output logic [LINE_W-1:0]     cache_sram_data,
  output logic                  cache_sram_enable,
  output logic                  cache_sram_write,
  input  logic [SRAM_TAG_W-1:0] sram_cache_tag,
  input  logic [LINE_W-1:0]     sram_cache_data,
  input  logic                  sram_hit
);

  state_t            state_q, state_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q,  mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [LINE_W-1:0] mem_data_q,   mem_data_d;

  logic              req;
  logic              victim_dirty;
  logic [TAG_W-1:0]  cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [WSEL_W-1:0] cpu_word;
  logic [LINE_W-1:0] store_line;
  logic              unused_addr_bits;

  assign req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign cpu_tag      = bus.cpu_addr_i[TAG_LSB +: TAG_W];
  assign cpu_index    = bus.cpu_addr_i[INDEX_LSB +: INDEX_W];
  assign cpu_word     = bus.cpu_addr_i[WORD_LSB +: WSEL_W];
  assign victim_dirty = sram_cache_tag[VALID_BIT] & sram_cache_tag[DIRTY_BIT];
  assign unused_addr_bits = ^bus.cpu_addr_i[WORD_LSB-1:0];

  dcache_word_mux u_word_mux (
    .word_sel_i (cpu_word),
    .line_i     (sram_cache_data),
    .wdata_i    (bus.cpu_data_i),
    .rdata_o    (bus.cpu_data_o),
    .line_o     (store_line)
  );

  // State and registered memory-side outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (req && !sram_hit) state_d = MISS;
      MISS:       state_d = victim_dirty ? WRITEBACK : READMISS;
      WRITEBACK:  if (bus.mem_ack_i) state_d = READMISS;
      READMISS:   if (bus.mem_ack_i) state_d = READMISSOK;
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // The mem_*_d values computed here become visible one cycle later,
  // so the memory request is always presented from registers.
  always_comb begin
    mem_enable_d      = mem_enable_q;
    mem_write_d       = mem_write_q;
    mem_addr_d        = mem_addr_q;
    mem_data_d        = mem_data_q;
    cache_sram_tag    = {1'b1, 1'b0, cpu_tag};
    cache_sram_data   = store_line;
    cache_sram_enable = 1'b0;
    cache_sram_write  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cache_sram_enable = req;
        if (req && sram_hit && bus.cpu_MemWrite_i) begin
          cache_sram_write = 1'b1;
          cache_sram_tag   = {1'b1, 1'b1, cpu_tag};
        end
      end
      MISS: begin
        mem_enable_d = 1'b1;
        mem_data_d   = sram_cache_data;
        if (victim_dirty) begin
          mem_write_d = 1'b1;
          mem_addr_d  = line_addr(sram_cache_tag[TAG_W-1:0], cpu_index);
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(cpu_tag, cpu_index);
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(cpu_tag, cpu_index);
        end
      end
      READMISS: begin
        if (bus.mem_ack_i) begin
          mem_enable_d      = 1'b0;
          cache_sram_enable = 1'b1;
          cache_sram_write  = 1'b1;
          cache_sram_tag    = {1'b1, 1'b0, cpu_tag};
          cache_sram_data   = bus.mem_data_i;
        end
      end
      READMISSOK: ;
      default: ;
    endcase
    if (rst_i) begin
      cache_sram_enable = 1'b0;
      cache_sram_write  = 1'b0;
    end
  end

  assign cache_sram_index = cpu_index;
  assign bus.cpu_stall_o  = req & ~((state_q == IDLE) & sram_hit) & ~rst_i;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  dcache_controller_if bus();

  logic [3:0]   cache_sram_index;
  logic [24:0]  cache_sram_tag;
  logic [255:0] cache_sram_data;
  logic         cache_sram_enable, cache_sram_write;
  logic [24:0]  sram_cache_tag;
  logic [255:0] sram_cache_data;
  logic         sram_hit;

  dcache_controller dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .bus               (bus),
    .cache_sram_index  (cache_sram_index),
    .cache_sram_tag    (cache_sram_tag),
    .cache_sram_data   (cache_sram_data),
    .cache_sram_enable (cache_sram_enable),
    .cache_sram_write  (cache_sram_write),
    .sram_cache_tag    (sram_cache_tag),
    .sram_cache_data   (sram_cache_data),
    .sram_hit          (sram_hit)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM environment model (2 ways x 16 sets) ----------------
  logic         s_valid [16][2];
  logic         s_dirty [16][2];
  logic [22:0]  s_tag   [16][2];
  logic [255:0] s_data  [16][2];
  logic         s_lru   [16];
  logic         sram_clr;
  logic         h0, h1, rd_way, wr_way;
  int unsigned  sram_wr_cnt = 0;
  logic [24:0]  last_wtag;

  always_comb begin
    h0 = s_valid[cache_sram_index][0] && (s_tag[cache_sram_index][0] == cache_sram_tag[22:0]);
    h1 = s_valid[cache_sram_index][1] && (s_tag[cache_sram_index][1] == cache_sram_tag[22:0]);
    rd_way = h0 ? 1'b0 : (h1 ? 1'b1 : s_lru[cache_sram_index]);
    sram_hit = h0 | h1;
    sram_cache_tag = {s_valid[cache_sram_index][rd_way], s_dirty[cache_sram_index][rd_way],
                      s_tag[cache_sram_index][rd_way]};
    sram_cache_data = s_data[cache_sram_index][rd_way];
  end

  assign wr_way = cache_sram_tag[23] ? ~h0 : s_lru[cache_sram_index];

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 16; i++) begin
        s_lru[i] <= 1'b0;
        for (int j = 0; j < 2; j++) begin
          s_valid[i][j] <= 1'b0;
          s_dirty[i][j] <= 1'b0;
          s_tag[i][j]   <= '0;
          s_data[i][j]  <= '0;
        end
      end
    end else if (cache_sram_enable && cache_sram_write) begin
      sram_wr_cnt <= sram_wr_cnt + 1;
      last_wtag   <= cache_sram_tag;
      if (!cache_sram_tag[23]) s_lru[cache_sram_index] <= ~s_lru[cache_sram_index];
      s_valid[cache_sram_index][wr_way] <= cache_sram_tag[24];
      s_dirty[cache_sram_index][wr_way] <= cache_sram_tag[23];
      s_tag[cache_sram_index][wr_way]   <= cache_sram_tag[22:0];
      s_data[cache_sram_index][wr_way]  <= cache_sram_data;
    end
  end

  // ---------------- reference: memory image and cache residency ----------------
  logic [31:0]  gold    [logic [31:0]];   // latest CPU-visible word per word address
  logic [255:0] backing [logic [31:0]];   // main memory lines
  logic [22:0]  m_tag   [16][2];          // resident lines per set, oldest first
  bit           m_dirty [16][2];
  int unsigned  m_cnt   [16];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h3C5AA5C3;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return gold.exists(k) ? gold[k] : init_word(k);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_rd({a[31:5], 5'b0} + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] merged(input logic [31:0] a, input logic [31:0] wd);
    logic [255:0] l;
    l = gold_line(a);
    l[a[4:2]*32 +: 32] = wd;
    return l;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    logic [255:0] l;
    logic [31:0]  la;
    la = {a[31:5], 5'b0};
    gold[{a[31:2], 2'b00}] = v;
    l = mem_line(la);
    l[a[4:2]*32 +: 32] = v;
    backing[la] = l;
  endtask

  // ---------------- memory responder ----------------
  int unsigned lat_wb = 1, lat_rd = 1;
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1 bus.mem_ack_i = 1'b0;
      #1;
      if (bus.mem_enable_o && !rst_i) begin
        cnt++;
        if (cnt >= (bus.mem_write_o ? lat_wb : lat_rd)) begin
          cnt = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o) backing[bus.mem_addr_o] = bus.mem_data_o;
          else bus.mem_data_i = mem_line(bus.mem_addr_o);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  bit          active = 0, done = 0, saw_wb = 0, mem_seen = 0;
  logic        exp_hit, exp_vd, exp_load;
  logic [31:0] exp_addr, exp_wdata, exp_data, exp_wb_addr, exp_rd_addr;
  int unsigned exp_stall, stall_cnt, last_stall;
  logic [31:0] last_data, last_wb_addr, last_rd_addr;

  always @(negedge clk) begin
    if (active && !rst_i) begin
      if (exp_hit) chk("mem_idle_on_hit", bus.mem_enable_o, 1'b0);
      if (bus.mem_enable_o) begin
        mem_seen = 1;
        if (bus.mem_write_o) begin
          saw_wb = 1;
          last_wb_addr = bus.mem_addr_o;
          chk("wb_needed", exp_vd, 1'b1);
          chk("wb_addr", bus.mem_addr_o, exp_wb_addr);
          chk("wb_data", bus.mem_data_o, gold_line(exp_wb_addr));
        end else begin
          last_rd_addr = bus.mem_addr_o;
          chk("rd_addr", bus.mem_addr_o, exp_rd_addr);
          chk("wb_before_rd", saw_wb, exp_vd);
        end
      end
      if (cache_sram_enable && cache_sram_write) begin
        if (bus.mem_ack_i) begin
          chk("refill_tag", cache_sram_tag, {2'b10, exp_addr[31:9]});
          chk("refill_data", cache_sram_data, bus.mem_data_i);
          chk("refill_line", bus.mem_data_i, gold_line(exp_addr));
        end else begin
          chk("store_on_load", exp_load, 1'b0);
          chk("store_tag", cache_sram_tag, {2'b11, exp_addr[31:9]});
          chk("store_line", cache_sram_data, merged(exp_addr, exp_wdata));
        end
      end
      if (!done) begin
        if (bus.cpu_stall_o) stall_cnt++;
        else begin
          done = 1;
          last_stall = stall_cnt;
          chk("stall_cycles", stall_cnt, exp_stall);
          if (exp_load) begin
            last_data = bus.cpu_data_o;
            chk("load_data", bus.cpu_data_o, exp_data);
          end
        end
      end
    end
  end

  // ---------------- driver: one CPU access, prediction then model update ----------------
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input int unsigned nwb, input int unsigned nrd);
    int unsigned s;
    logic [22:0] t;
    s = a[8:5];
    t = a[31:9];
    exp_hit = 1'b0;
    for (int k = 0; k < int'(m_cnt[s]); k++) if (m_tag[s][k] == t) exp_hit = 1'b1;
    exp_vd      = !exp_hit && (m_cnt[s] == 2) && m_dirty[s][0];
    exp_wb_addr = {m_tag[s][0], a[8:5], 5'b0};
    exp_rd_addr = {t, a[8:5], 5'b0};
    exp_stall   = exp_hit ? 0 : (exp_vd ? nwb + nrd + 3 : nrd + 3);
    exp_load    = !wr;
    exp_addr    = a;
    exp_wdata   = wd;
    exp_data    = gold_rd(a);
    lat_wb = nwb;
    lat_rd = nrd;
    stall_cnt = 0; done = 0; saw_wb = 0; mem_seen = 0;
    bus.cpu_addr_i = a;
    bus.cpu_data_i = wd;
    bus.cpu_MemRead_i = rd;
    bus.cpu_MemWrite_i = wr;
    active = 1;
    for (int c = 0; c < 400 && !done; c++) @(posedge clk);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%0h got no completion expected completion", a);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    #1;
    active = 0;
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    if (!exp_hit) begin
      if (m_cnt[s] == 2) begin
        m_tag[s][0] = m_tag[s][1];
        m_dirty[s][0] = m_dirty[s][1];
        m_cnt[s] = 1;
      end
      m_tag[s][m_cnt[s]] = t;
      m_dirty[s][m_cnt[s]] = 0;
      m_cnt[s]++;
    end
    if (wr) begin
      for (int k = 0; k < int'(m_cnt[s]); k++) if (m_tag[s][k] == t) m_dirty[s][k] = 1;
      gold[{a[31:2], 2'b00}] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] ln;
    int unsigned  wcnt;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    rst_i = 1'b1;
    sram_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.cpu_MemRead_i = 1'b1;
    #1;
    chk("rst_stall_forced_low", bus.cpu_stall_o, 1'b0);
    chk("rst_mem_enable", bus.mem_enable_o, 1'b0);
    chk("rst_mem_write", bus.mem_write_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_data", bus.mem_data_o, 256'h0);
    bus.cpu_MemRead_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sram_clr = 1'b0;
    @(posedge clk);
    #1;

    // clean load miss with a known memory word
    poke(32'h0000_0124, 32'hDEADBEEF);
    access(32'h0000_0124, 1'b1, 1'b0, 32'h0, 1, 10);
    chk("t1_stall", last_stall, 13);
    chk("t1_data", last_data, 32'hDEADBEEF);
    chk("t1_rd_addr", last_rd_addr, 32'h0000_0120);

    // repeat load hits
    access(32'h0000_0124, 1'b1, 1'b0, 32'h0, 1, 1);
    chk("t2_stall", last_stall, 0);
    chk("t2_data", last_data, 32'hDEADBEEF);
    chk("t2_no_mem", mem_seen, 1'b0);

    // store hit then load it back
    access(32'h0000_0128, 1'b0, 1'b1, 32'h12345678, 1, 1);
    chk("t3_stall", last_stall, 0);
    chk("t3_wtag", last_wtag, {2'b11, 23'h0});
    access(32'h0000_0128, 1'b1, 1'b0, 32'h0, 1, 1);
    chk("t3_load", last_data, 32'h12345678);

    // fill set 9, then evict the dirty oldest line
    access(32'h0000_0320, 1'b1, 1'b0, 32'h0, 1, 2);
    access(32'h0000_0520, 1'b1, 1'b0, 32'h0, 4, 5);
    chk("t4_saw_wb", saw_wb, 1'b1);
    chk("t4_wb_addr", last_wb_addr, 32'h0000_0120);
    chk("t4_rd_addr", last_rd_addr, 32'h0000_0520);
    chk("t4_stall", last_stall, 12);
    ln = backing[32'h0000_0120];
    chk("t4_wb_word", ln[95:64], 32'h12345678);

    // read and write together on a hit act as a store
    access(32'h0000_0324, 1'b1, 1'b1, 32'hCAFEF00D, 1, 1);
    chk("t5_stall", last_stall, 0);
    chk("t5_wtag_vd", last_wtag[24:23], 2'b11);
    access(32'h0000_0324, 1'b1, 1'b0, 32'h0, 1, 1);
    chk("t5_load", last_data, 32'hCAFEF00D);

    // reset while the refill is outstanding
    lat_rd = 50;
    bus.cpu_addr_i = 32'h0000_00A0;
    bus.cpu_MemRead_i = 1'b1;
    for (int c = 0; c < 20 && !(bus.mem_enable_o && !bus.mem_write_o); c++) @(negedge clk);
    chk("t6_in_readmiss", bus.mem_enable_o && !bus.mem_write_o, 1'b1);
    @(negedge clk);
    wcnt = sram_wr_cnt;
    rst_i = 1'b1;
    #1;
    chk("t6_enable_drop", bus.mem_enable_o, 1'b0);
    chk("t6_stall_low", bus.cpu_stall_o, 1'b0);
    chk("t6_addr_clear", bus.mem_addr_o, 32'h0);
    bus.cpu_MemRead_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("t6_no_sram_write", sram_wr_cnt, wcnt);
    @(posedge clk);
    #1;
    access(32'h0000_00A0, 1'b1, 1'b0, 32'h0, 1, 3);
    chk("t6_remiss_stall", last_stall, 6);

    // randomized traffic over a few sets and conflicting tags
    for (int n = 0; n < 200; n++) begin
      int unsigned kind, s, t, w;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      s = $urandom_range(0, 3);
      t = $urandom_range(0, 3);
      w = $urandom_range(0, 7);
      a = {23'(64 + t), 4'(s + 10), 3'(w), 2'b00};
      access(a, kind != 1, kind != 0, $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
